// File: rtl/fir_tap_sequencer.sv
// FIR control sequencer: clears the delay line, then per accepted sample does WRITE, NTAP MAC issues, a MAC_LAT drain, and a DONE latch.
// Tick-to-valid latency is NTAP+2+MAC_LAT cycles; ticks outside IDLE are dropped with an overrun pulse, and cload aborts a run.
module fir_tap_sequencer #(
    parameter int NTAP    = 64,
    parameter int AW      = 6,
    parameter int MAC_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_tick,
    input  logic [15:0]   din,
    input  logic          cload,
    input  logic [15:0]   acc,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_waddr,
    output logic [15:0]   dmem_wdata,
    output logic [AW-1:0] dmem_raddr,
    output logic [AW-1:0] cmem_raddr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic [15:0]   dout,
    output logic          valid,
    output logic          busy,
    output logic          overrun
);
    localparam int DW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [AW:0]   K_CLEAR_END = (AW+1)'(NTAP);
    localparam logic [AW:0]   K_LAST      = (AW+1)'(NTAP - 1);
    localparam logic [DW-1:0] D_LAST      = DW'(MAC_LAT);

    typedef enum logic [2:0] {CLEAR, IDLE, WRITE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [AW-1:0] wptr, wptr_n;
    logic [AW:0]   k, k_n, k_inc;
    logic [DW-1:0] dcnt, dcnt_n;

    logic          we_n, mac_en_n, mac_clr_n, valid_n, busy_n, overrun_n;
    logic [AW-1:0] waddr_n, raddr_n, craddr_n;
    logic [15:0]   wdata_n, dout_n;

    assign k_inc = k + (AW+1)'(1);

    // Outputs are registered from the next state, so each output cycle shows the state being entered.
    always_comb begin
        state_n   = state;
        wptr_n    = wptr;
        k_n       = k;
        dcnt_n    = dcnt;
        we_n      = 1'b0;
        waddr_n   = dmem_waddr;
        wdata_n   = dmem_wdata;
        raddr_n   = dmem_raddr;
        craddr_n  = cmem_raddr;
        mac_en_n  = 1'b0;
        mac_clr_n = 1'b0;
        dout_n    = dout;
        valid_n   = 1'b0;
        overrun_n = sample_tick && ((state != IDLE) || cload);

        case (state)
            CLEAR: begin
                // k counts slots already cleared; cload has no effect here.
                if (k == K_CLEAR_END) begin
                    state_n = IDLE;
                    k_n     = '0;
                end else begin
                    we_n    = 1'b1;
                    waddr_n = k[AW-1:0];
                    wdata_n = '0;
                    k_n     = k_inc;
                end
            end
            IDLE: begin
                if (sample_tick && !cload) begin
                    state_n = WRITE;
                    we_n    = 1'b1;
                    waddr_n = wptr;
                    wdata_n = din;
                end
            end
            WRITE: begin
                if (cload) begin
                    state_n = IDLE;
                end else begin
                    state_n   = RUN;
                    k_n       = '0;
                    mac_en_n  = 1'b1;
                    mac_clr_n = 1'b1;
                    craddr_n  = '0;
                    raddr_n   = wptr;
                end
            end
            RUN: begin
                if (cload) begin
                    state_n = IDLE;
                end else if (k == K_LAST) begin
                    state_n = DRAIN;
                    dcnt_n  = DW'(1);
                end else begin
                    k_n      = k_inc;
                    mac_en_n = 1'b1;
                    craddr_n = k_inc[AW-1:0];
                    raddr_n  = wptr - k_inc[AW-1:0];
                end
            end
            DRAIN: begin
                if (cload) begin
                    state_n = IDLE;
                end else if (dcnt == D_LAST) begin
                    state_n = DONE;
                    dout_n  = acc;
                    valid_n = 1'b1;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                wptr_n  = wptr + AW'(1);
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            wptr       <= '0;
            k          <= '0;
            dcnt       <= '0;
            dmem_we    <= 1'b0;
            dmem_waddr <= '0;
            dmem_wdata <= '0;
            dmem_raddr <= '0;
            cmem_raddr <= '0;
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            wptr       <= wptr_n;
            k          <= k_n;
            dcnt       <= dcnt_n;
            dmem_we    <= we_n;
            dmem_waddr <= waddr_n;
            dmem_wdata <= wdata_n;
            dmem_raddr <= raddr_n;
            cmem_raddr <= craddr_n;
            mac_en     <= mac_en_n;
            mac_clr    <= mac_clr_n;
            dout       <= dout_n;
            valid      <= valid_n;
            busy       <= busy_n;
            overrun    <= overrun_n;
        end
    end
endmodule
